// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gpu_pkg
// Description : Shared types and constants for the GPU core control path.
//               Core/LSU state encodings, the fetcher "FETCHED" code, and a
//               width helper that never returns zero.
// Revision    : 1.0  initial multi-warp release
// ============================================================================
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  // Index width for n items; a single item still needs a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : warp_scheduler_if
// Description : Bundles the scheduler's control inputs (launch, fetcher and
//               decoder status, per-lane LSU state and next PC) and its
//               outputs (core state, issuing PC, warp id, lane mask, flags).
//   slave  : the scheduler side (consumes status, drives core_state etc.)
//   master : the surrounding core (drives status, consumes core_state etc.)
// Revision    : 1.0  initial multi-warp release
// ============================================================================
interface warp_scheduler_if import gpu_pkg::*; #(
  parameter int NUM_WARPS        = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8
) ();

  localparam int WID_W = clog2_min1(NUM_WARPS);
  localparam int TC_W  = $clog2(NUM_WARPS * THREADS_PER_WARP) + 1;

  logic                               start;
  logic [TC_W-1:0]                    thread_count;
  logic [2:0]                         fetcher_state;
  logic                               decoded_mem_read_enable;
  logic                               decoded_mem_write_enable;
  logic                               decoded_ret;
  logic [2*THREADS_PER_WARP-1:0]      lsu_state;
  logic [PC_BITS*THREADS_PER_WARP-1:0] next_pc;

  logic [2:0]                         core_state;
  logic [PC_BITS-1:0]                 current_pc;
  logic [WID_W-1:0]                   warp_id;
  logic [THREADS_PER_WARP-1:0]        lane_mask;
  logic                               diverged;
  logic                               done;

  modport slave (
    input  start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, warp_id, lane_mask, diverged, done
  );

  modport master (
    output start, thread_count, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, warp_id, lane_mask, diverged, done
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches the request vector
//               starting just above last_i and wrapping around; last_i itself
//               is the final candidate, so it wins only when it is the sole
//               requester.
//   req_i      [NUM_REQ] request vector
//   last_i     [IDX_W]   previous grant index
//   grant_oh_o [NUM_REQ] one-hot grant (all zero when nothing requests)
//   grant_idx_o[IDX_W]   grant index (0 when nothing requests)
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [IDX_W-1:0]   last_i,
  output logic      [NUM_REQ-1:0] grant_oh_o,
  output logic      [IDX_W-1:0]   grant_idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found             = 1'b1;
        grant_oh_o[cand]  = 1'b1;
        grant_idx_o       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler
// Description : Time-multiplexes NUM_WARPS warps of THREADS_PER_WARP lanes over
//               one fetch/decode path. Keeps a PC per warp, issues one
//               instruction at a time in round-robin warp order, retires warps
//               on RET and raises done once every launched warp has retired.
//   clk, reset : clock and synchronous active-high reset
//   bus        : warp_scheduler_if.slave
//     in  start, thread_count, fetcher_state, decoded_mem_read_enable,
//         decoded_mem_write_enable, decoded_ret, lsu_state, next_pc
//     out core_state, current_pc, warp_id, lane_mask, diverged, done
// Revision    : 1.0  initial multi-warp release
// ============================================================================
module warp_scheduler import gpu_pkg::*; #(
  parameter int NUM_WARPS        = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8
) (
  input wire logic         clk,
  input wire logic         reset,
  warp_scheduler_if.slave  bus
);

  localparam int WID_W = clog2_min1(NUM_WARPS);

  core_state_t             state_q, state_d;
  logic [WID_W-1:0]        warp_id_q, warp_id_d;
  logic [PC_BITS-1:0]      pc_q [NUM_WARPS];
  logic [PC_BITS-1:0]      pc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0]    valid_q, valid_d;
  logic                    diverged_q, diverged_d;

  logic [NUM_WARPS-1:0]        w_launch_valid;
  logic [THREADS_PER_WARP-1:0] w_lane_active;
  logic                        w_lsu_busy;
  logic [PC_BITS-1:0]          w_lead_pc;
  logic                        w_have_lead;
  logic                        w_disagree;
  logic [NUM_WARPS-1:0]        w_post_valid;
  logic [NUM_WARPS-1:0]        w_arb_req;
  logic [WID_W-1:0]            w_arb_last;
  logic [NUM_WARPS-1:0]        w_grant_oh;
  logic [WID_W-1:0]            w_grant_idx;
  logic                        w_grant_any;

  // A warp is launched when its lane 0 falls inside the thread count.
  generate
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_launch
      assign w_launch_valid[g] =
        32'(bus.thread_count) > 32'(g * THREADS_PER_WARP);
    end
  endgenerate

  always_comb begin
    w_lane_active = '0;
    for (int unsigned l = 0; l < THREADS_PER_WARP; l++) begin
      w_lane_active[l] = (32'(warp_id_q) * THREADS_PER_WARP + l)
                         < 32'(bus.thread_count);
    end
  end

  // Only active lanes can hold up WAIT; idle/done lanes and lanes beyond the
  // thread count are ignored.
  always_comb begin
    w_lsu_busy = 1'b0;
    for (int l = 0; l < THREADS_PER_WARP; l++) begin
      if (w_lane_active[l] &&
          (bus.lsu_state[2*l +: 2] == LSU_REQUESTING ||
           bus.lsu_state[2*l +: 2] == LSU_WAITING)) begin
        w_lsu_busy = 1'b1;
      end
    end
  end

  // The lowest active lane supplies the warp's new PC; any other active lane
  // with a different target marks divergence.
  always_comb begin
    w_lead_pc   = '0;
    w_have_lead = 1'b0;
    w_disagree  = 1'b0;
    for (int l = 0; l < THREADS_PER_WARP; l++) begin
      if (w_lane_active[l]) begin
        if (!w_have_lead) begin
          w_lead_pc   = bus.next_pc[PC_BITS*l +: PC_BITS];
          w_have_lead = 1'b1;
        end else if (bus.next_pc[PC_BITS*l +: PC_BITS] != w_lead_pc) begin
          w_disagree = 1'b1;
        end
      end
    end
  end

  // One arbiter serves both the launch pick (search from warp 0) and the
  // post-UPDATE pick (search above the current warp over the retired set).
  always_comb begin
    w_post_valid = valid_q;
    if (state_q == CORE_UPDATE && bus.decoded_ret) begin
      w_post_valid[warp_id_q] = 1'b0;
    end
    if (state_q == CORE_IDLE) begin
      w_arb_req  = w_launch_valid;
      w_arb_last = WID_W'(NUM_WARPS - 1);
    end else begin
      w_arb_req  = w_post_valid;
      w_arb_last = warp_id_q;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_WARPS),
    .IDX_W   (WID_W)
  ) u_rr_arbiter (
    .req_i       (w_arb_req),
    .last_i      (w_arb_last),
    .grant_oh_o  (w_grant_oh),
    .grant_idx_o (w_grant_idx)
  );

  assign w_grant_any = |w_grant_oh;

  always_comb begin
    state_d    = state_q;
    warp_id_d  = warp_id_q;
    valid_d    = valid_q;
    diverged_d = diverged_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pc_d[w] = pc_q[w];
    end

    case (state_q)
      CORE_IDLE: begin
        if (bus.start) begin
          valid_d = w_launch_valid;
          for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w] = '0;
          end
          if (bus.thread_count == '0 || !w_grant_any) begin
            state_d = CORE_DONE;
          end else begin
            warp_id_d = w_grant_idx;
            state_d   = CORE_FETCH;
          end
        end
      end
      CORE_FETCH: begin
        if (bus.fetcher_state == FETCHER_FETCHED) begin
          state_d = CORE_DECODE;
        end
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (bus.decoded_mem_read_enable || bus.decoded_mem_write_enable) begin
          if (!w_lsu_busy) begin
            state_d = CORE_EXECUTE;
          end
        end else begin
          state_d = CORE_EXECUTE;
        end
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        valid_d = w_post_valid;
        if (!bus.decoded_ret && w_have_lead) begin
          pc_d[warp_id_q] = w_lead_pc;
          if (w_disagree) begin
            diverged_d = 1'b1;
          end
        end
        if (w_grant_any) begin
          warp_id_d = w_grant_idx;
          state_d   = CORE_FETCH;
        end else begin
          state_d = CORE_DONE;
        end
      end
      CORE_DONE: state_d = CORE_DONE;
      default:   state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CORE_IDLE;
      warp_id_q  <= '0;
      valid_q    <= '0;
      diverged_q <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      warp_id_q  <= warp_id_d;
      valid_q    <= valid_d;
      diverged_q <= diverged_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= pc_d[w];
      end
    end
  end

  assign bus.core_state = state_q;
  assign bus.current_pc = pc_q[warp_id_q];
  assign bus.warp_id    = warp_id_q;
  // No warp is issuing outside a kernel, so the mask reads all-zero there.
  assign bus.lane_mask  = (state_q == CORE_IDLE || state_q == CORE_DONE)
                          ? '0 : w_lane_active;
  assign bus.diverged   = diverged_q;
  assign bus.done       = (state_q == CORE_DONE);

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_scheduler
// Description : Self-checking bench for warp_scheduler. Plays the fetcher,
//               decoder and LSUs with randomized programs, delays and next-PC
//               values, and compares against a warp-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_warp_scheduler;
  import gpu_pkg::*;

  localparam int NW  = 4;
  localparam int TPW = 4;
  localparam int PCB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .PC_BITS(PCB)) bus ();

  warp_scheduler #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .PC_BITS(PCB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc    [NW];
  bit m_valid [NW];
  int m_rem   [NW];
  bit m_div;
  int m_warp;
  int m_tc;

  function automatic bit m_active(input int w, input int l);
    return (w * TPW + l) < m_tc;
  endfunction

  function automatic logic [TPW-1:0] m_mask(input int w);
    logic [TPW-1:0] m;
    for (int l = 0; l < TPW; l++) m[l] = m_active(w, l);
    return m;
  endfunction

  // Next valid warp strictly after 'last', wrapping; 'last' itself comes last.
  function automatic int m_next(input int last);
    for (int i = 1; i <= NW; i++) begin
      if (m_valid[(last + i) % NW]) return (last + i) % NW;
    end
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_drive();
    bus.fetcher_state            = 3'b000;
    bus.decoded_mem_read_enable  = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret              = 1'b0;
    bus.lsu_state                = '0;
    bus.next_pc                  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    clear_drive();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_state",    bus.core_state, CORE_IDLE);
    check_eq("rst_warp_id",  bus.warp_id,    0);
    check_eq("rst_mask",     bus.lane_mask,  0);
    check_eq("rst_pc",       bus.current_pc, 0);
    check_eq("rst_diverged", bus.diverged,   0);
    check_eq("rst_done",     bus.done,       0);
    reset = 1'b0;
    m_div = 1'b0;
  endtask

  task automatic launch(input int tc, input bit directed);
    @(negedge clk);
    bus.thread_count = tc[4:0];
    bus.start        = 1'b1;
    m_tc = tc;
    for (int w = 0; w < NW; w++) begin
      m_valid[w] = (w * TPW) < tc;
      m_pc[w]    = 0;
      m_rem[w]   = directed ? 2 : int'($urandom_range(0, 3));
    end
    m_warp = m_next(NW - 1);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("launch_state", bus.core_state, (tc == 0) ? CORE_DONE : CORE_FETCH);
    check_eq("launch_done",  bus.done,       (tc == 0) ? 1 : 0);
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge
  // after UPDATE, or right after the reset when the abort warp reaches WAIT.
  task automatic run_instr(output bit ended, output bit aborted,
                           input int abort_warp, input bit directed);
    int w, fdelay, wlen, n, k, base, lane_val[TPW];
    bit ret, mem, rd;
    logic [PCB*TPW-1:0] np;
    logic [2*TPW-1:0]   lsu;
    ended   = 1'b0;
    aborted = 1'b0;
    w = m_warp;
    check_eq("issue_state",    bus.core_state, CORE_FETCH);
    check_eq("issue_warp",     bus.warp_id,    w);
    check_eq("issue_pc",       bus.current_pc, m_pc[w]);
    check_eq("issue_mask",     bus.lane_mask,  m_mask(w));
    check_eq("issue_diverged", bus.diverged,   m_div);

    ret  = (m_rem[w] == 0);
    mem  = !ret && !directed && ($urandom_range(0, 1) == 1);
    rd   = ($urandom_range(0, 1) == 1);
    base = (m_pc[w] + 1 + int'($urandom_range(0, 3))) & 'hFF;
    for (int l = 0; l < TPW; l++)
      lane_val[l] = m_active(w, l) ? base : int'($urandom_range(0, 255));
    if (!directed && $urandom_range(0, 3) == 0) begin
      k = int'($urandom_range(1, TPW - 1));
      lane_val[k] = (base + 1) & 'hFF;
    end
    for (int l = 0; l < TPW; l++) begin
      np[PCB*l +: PCB] = lane_val[l][PCB-1:0];
      lsu[2*l +: 2]    = ($urandom_range(0, 1) == 1) ? LSU_REQUESTING : LSU_WAITING;
    end
    bus.decoded_ret              = ret;
    bus.decoded_mem_read_enable  = mem && rd;
    bus.decoded_mem_write_enable = mem && !rd;
    bus.next_pc                  = np;
    bus.lsu_state                = lsu;
    fdelay = int'($urandom_range(1, 4));
    wlen   = mem ? int'($urandom_range(1, 5)) : 1;
    if ($urandom_range(0, 2) == 0) bus.start = 1'b1;  // must be ignored

    n = 0;
    while (1) begin
      n++;
      if (n == fdelay) bus.fetcher_state = FETCHER_FETCHED;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.core_state != CORE_FETCH || n >= 20) break;
    end
    bus.fetcher_state = 3'b000;
    check_eq("fetch_len",    n,              fdelay);
    check_eq("decode_state", bus.core_state, CORE_DECODE);
    @(negedge clk);
    check_eq("request_state", bus.core_state, CORE_REQUEST);
    @(negedge clk);
    check_eq("wait_state", bus.core_state, CORE_WAIT);

    if (w == abort_warp) begin
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_state",    bus.core_state, CORE_IDLE);
      check_eq("abort_warp_id",  bus.warp_id,    0);
      check_eq("abort_done",     bus.done,       0);
      check_eq("abort_pc",       bus.current_pc, 0);
      check_eq("abort_diverged", bus.diverged,   0);
      reset = 1'b0;
      clear_drive();
      m_div   = 1'b0;
      aborted = 1'b1;
      return;
    end

    k = 0;
    while (1) begin
      k++;
      if (mem && k == wlen) begin
        for (int l = 0; l < TPW; l++)
          if (m_active(w, l)) lsu[2*l +: 2] = LSU_DONE;
        bus.lsu_state = lsu;
      end
      @(negedge clk);
      if (bus.core_state != CORE_WAIT || k >= 20) break;
    end
    check_eq("wait_len",      k,              wlen);
    check_eq("execute_state", bus.core_state, CORE_EXECUTE);
    check_eq("execute_pc",    bus.current_pc, m_pc[w]);
    check_eq("execute_mask",  bus.lane_mask,  m_mask(w));
    @(negedge clk);
    check_eq("update_state", bus.core_state, CORE_UPDATE);
    check_eq("update_warp",  bus.warp_id,    w);

    if (ret) begin
      m_valid[w] = 1'b0;
    end else begin
      m_pc[w] = lane_val[0];
      for (int l = 1; l < TPW; l++)
        if (m_active(w, l) && lane_val[l] != lane_val[0]) m_div = 1'b1;
      m_rem[w]--;
    end
    n = m_next(w);
    @(negedge clk);
    clear_drive();
    if (n < 0) begin
      check_eq("end_state",    bus.core_state, CORE_DONE);
      check_eq("end_done",     bus.done,       1);
      check_eq("end_diverged", bus.diverged,   m_div);
      ended = 1'b1;
    end else begin
      m_warp = n;
    end
  endtask

  task automatic run_kernel(input int tc, input int abort_warp,
                            input bit rst_first, input bit directed);
    bit ended, aborted;
    int cnt;
    if (rst_first) do_reset();
    launch(tc, directed);
    ended   = (tc == 0);
    aborted = 1'b0;
    cnt     = 0;
    while (!ended && !aborted && cnt < 40) begin
      run_instr(ended, aborted, abort_warp, directed);
      cnt++;
    end
    if (aborted) return;
    check_eq("kernel_finished", ended, 1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("done_hold_state", bus.core_state, CORE_DONE);
    check_eq("done_hold",       bus.done,       1);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.thread_count = '0;
    clear_drive();
    m_div = 1'b0;
    m_tc  = 0;

    run_kernel(16, -1, 1'b1, 1'b1);   // full block, fixed 3-instruction program
    run_kernel(6,  -1, 1'b1, 1'b0);   // two warps, partial mask on warp 1
    run_kernel(0,  -1, 1'b1, 1'b0);   // empty block
    run_kernel(16,  2, 1'b1, 1'b0);   // reset during warp 2 WAIT
    run_kernel(16, -1, 1'b0, 1'b0);   // relaunch after abort
    for (int i = 0; i < 8; i++)
      run_kernel(int'($urandom_range(1, 16)), -1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
